// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard control bundle: decode operand/destination info in, pipeline control and forwarding selects out.
// No storage of its own; timing is set by the controller attached to the slave modport.
// No flow control of its own; ext_stall carries the whole-pipeline hold request.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
);
  // Decode stage contents
  logic             id_valid;
  logic [RA_W-1:0]  id_src1;
  logic [RA_W-1:0]  id_src2;
  logic             id_two_src;
  logic [RA_W-1:0]  id_dest;
  logic             id_wb_en;
  logic             id_mem_r_en;
  // Pipeline events
  logic             branch_taken;
  logic             ext_stall;
  // Control back to the pipeline
  logic             freeze;
  logic             flush;
  logic             issue;
  logic             exe_valid;
  logic [2:0]       fwd_sel1;
  logic [2:0]       fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: presents decode info, consumes control
  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en,
    output branch_taken, ext_stall,
    input  freeze, flush, issue, exe_valid, fwd_sel1, fwd_sel2, stall_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en,
    input  branch_taken, ext_stall,
    output freeze, flush, issue, exe_valid, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: scoreboard of post-decode stages, stall/flush/issue decisions, forwarding selects.
// freeze/flush/issue are combinational (0 cycles); exe_valid, fwd_sel and stall_cnt are registered (1 cycle).
// ext_stall holds every piece of state and forces freeze; a hazard stalls decode unless a taken branch flushes it.
module pipe_hazard_ctrl #(
  parameter int DEPTH  = 3,
  parameter int RA_W   = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  // One scoreboard slot per post-decode stage; index 0 is EXE, DEPTH-1 is WB.
  typedef struct packed {
    logic            vld;
    logic [RA_W-1:0] dst;
    logic            wb_en;
    logic            mem_r_en;
  } sb_ent_t;

  localparam sb_ent_t BUBBLE = '0;

  // Stages whose result is not yet in the register file when decode reads it.
  // WB (DEPTH-1) writes before the read in the same cycle, so it never stalls.
  localparam logic [DEPTH-1:0] STALL_WIN = {1'b0, {(DEPTH-1){1'b1}}};

  sb_ent_t          sb_q [DEPTH];
  sb_ent_t          sb_d [DEPTH];
  logic [2:0]       fwd_sel1_q, fwd_sel1_d;
  logic [2:0]       fwd_sel2_q, fwd_sel2_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic             hazard;
  logic             flush;
  logic             issue;
  logic             stall_cyc;
  logic [2:0]       sel1;
  logic [2:0]       sel2;
  sb_ent_t          id_ent;

  // Per-stage source match; src2 only counts when the instruction really reads it.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match1[k] = bus.id_valid & sb_q[k].vld & sb_q[k].wb_en &
                  (sb_q[k].dst == bus.id_src1);
      match2[k] = bus.id_valid & bus.id_two_src & sb_q[k].vld & sb_q[k].wb_en &
                  (sb_q[k].dst == bus.id_src2);
    end
  end

  // Hazard: with forwarding only a load still in EXE blocks; without it any
  // in-flight writer ahead of WB blocks. Reset presents the cleared scoreboard.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      hazard = (match1[0] | match2[0]) & sb_q[0].mem_r_en;
    end else begin
      hazard = |((match1 | match2) & STALL_WIN);
    end
    if (rst_i) begin
      hazard = 1'b0;
    end
  end

  // Forwarding select: youngest matching stage ahead of WB wins, so scan from
  // oldest to youngest and let later hits overwrite.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    if (FWD_EN != 0) begin
      for (int k = DEPTH - 2; k >= 0; k--) begin
        if (match1[k]) sel1 = 3'(k + 1);
        if (match2[k]) sel2 = 3'(k + 1);
      end
    end
  end

  assign flush     = bus.branch_taken & ~bus.ext_stall;
  assign issue     = bus.id_valid & ~hazard & ~flush & ~bus.ext_stall;
  assign stall_cyc = hazard & bus.id_valid & ~flush & ~bus.ext_stall;
  assign id_ent    = '{vld: 1'b1, dst: bus.id_dest, wb_en: bus.id_wb_en, mem_r_en: bus.id_mem_r_en};

  // Next state: advance the scoreboard one stage, inserting the decode entry or a bubble.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k];
    end
    fwd_sel1_d  = fwd_sel1_q;
    fwd_sel2_d  = fwd_sel2_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.ext_stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[0]    = BUBBLE;
      fwd_sel1_d = '0;
      fwd_sel2_d = '0;
      if (issue) begin
        sb_d[0]    = id_ent;
        fwd_sel1_d = sel1;
        fwd_sel2_d = sel2;
      end
      if (stall_cyc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset to an all-bubble pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= BUBBLE;
      end
      fwd_sel1_q  <= '0;
      fwd_sel2_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
      fwd_sel1_q  <= fwd_sel1_d;
      fwd_sel2_q  <= fwd_sel2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.flush     = flush;
  assign bus.freeze    = bus.ext_stall | (hazard & ~flush);
  assign bus.issue     = issue;
  assign bus.exe_valid = sb_q[0].vld;
  assign bus.fwd_sel1  = fwd_sel1_q;
  assign bus.fwd_sel2  = fwd_sel2_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations driven with identical stimulus.
// A: DEPTH=3 forwarding, B: DEPTH=3 stall-only, C: DEPTH=4 stall-only with a 4-bit stall counter.
// Each is compared every cycle against an in-bench model of the hazard rules.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, id_two_src, id_wb_en, id_mem_r_en, branch_taken, ext_stall;
  logic [3:0] id_src1, id_src2, id_dest;

  pipe_hazard_ctrl_if #(.RA_W(4), .CNT_W(16)) ifa ();
  pipe_hazard_ctrl_if #(.RA_W(4), .CNT_W(16)) ifb ();
  pipe_hazard_ctrl_if #(.RA_W(4), .CNT_W(4))  ifc ();

  assign ifa.id_valid = id_valid;     assign ifb.id_valid = id_valid;     assign ifc.id_valid = id_valid;
  assign ifa.id_src1 = id_src1;       assign ifb.id_src1 = id_src1;       assign ifc.id_src1 = id_src1;
  assign ifa.id_src2 = id_src2;       assign ifb.id_src2 = id_src2;       assign ifc.id_src2 = id_src2;
  assign ifa.id_two_src = id_two_src; assign ifb.id_two_src = id_two_src; assign ifc.id_two_src = id_two_src;
  assign ifa.id_dest = id_dest;       assign ifb.id_dest = id_dest;       assign ifc.id_dest = id_dest;
  assign ifa.id_wb_en = id_wb_en;     assign ifb.id_wb_en = id_wb_en;     assign ifc.id_wb_en = id_wb_en;
  assign ifa.id_mem_r_en = id_mem_r_en; assign ifb.id_mem_r_en = id_mem_r_en; assign ifc.id_mem_r_en = id_mem_r_en;
  assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken; assign ifc.branch_taken = branch_taken;
  assign ifa.ext_stall = ext_stall;   assign ifb.ext_stall = ext_stall;   assign ifc.ext_stall = ext_stall;

  pipe_hazard_ctrl #(.DEPTH(3), .RA_W(4), .FWD_EN(1), .CNT_W(16)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  pipe_hazard_ctrl #(.DEPTH(3), .RA_W(4), .FWD_EN(0), .CNT_W(16)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
  pipe_hazard_ctrl #(.DEPTH(4), .RA_W(4), .FWD_EN(0), .CNT_W(4))  dut_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

  // Outputs gathered per configuration
  logic        o_frz [3];
  logic        o_fl  [3];
  logic        o_iss [3];
  logic        o_ev  [3];
  logic [2:0]  o_s1  [3];
  logic [2:0]  o_s2  [3];
  logic [15:0] o_cnt [3];

  assign o_frz[0] = ifa.freeze;    assign o_frz[1] = ifb.freeze;    assign o_frz[2] = ifc.freeze;
  assign o_fl[0]  = ifa.flush;     assign o_fl[1]  = ifb.flush;     assign o_fl[2]  = ifc.flush;
  assign o_iss[0] = ifa.issue;     assign o_iss[1] = ifb.issue;     assign o_iss[2] = ifc.issue;
  assign o_ev[0]  = ifa.exe_valid; assign o_ev[1]  = ifb.exe_valid; assign o_ev[2]  = ifc.exe_valid;
  assign o_s1[0]  = ifa.fwd_sel1;  assign o_s1[1]  = ifb.fwd_sel1;  assign o_s1[2]  = ifc.fwd_sel1;
  assign o_s2[0]  = ifa.fwd_sel2;  assign o_s2[1]  = ifb.fwd_sel2;  assign o_s2[2]  = ifc.fwd_sel2;
  assign o_cnt[0] = ifa.stall_cnt; assign o_cnt[1] = ifb.stall_cnt; assign o_cnt[2] = {12'b0, ifc.stall_cnt};

  // Configuration table
  int    P_DEPTH [3] = '{3, 3, 4};
  bit    P_FWD   [3] = '{1'b1, 1'b0, 1'b0};
  int    P_MAX   [3] = '{65535, 65535, 15};
  string P_NAME  [3] = '{"A", "B", "C"};

  // Model: in-flight instructions by age (0 = just issued into EXE)
  bit       mv [3][8];
  bit [3:0] md [3][8];
  bit       mw [3][8];
  bit       mr [3][8];
  int       ms1 [3];
  int       ms2 [3];
  int       mcnt [3];
  bit       known = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Age of the youngest in-flight writer of register s that is not yet in the register file; -1 if none.
  function automatic int youngest(input int m, input logic [3:0] s);
    for (int k = 0; k <= P_DEPTH[m] - 2; k++) begin
      if (mv[m][k] && mw[m][k] && md[m][k] == s) return k;
    end
    return -1;
  endfunction

  // One clock: compare against the model, advance the model, return at the next negedge.
  task automatic cycle();
    int y1, y2;
    bit h, efl, eiss;
    #1;
    for (int m = 0; m < 3; m++) begin
      if (known) begin
        chk({P_NAME[m], ".exe_valid"}, int'(o_ev[m]), int'(mv[m][0]));
        chk({P_NAME[m], ".fwd_sel1"}, int'(o_s1[m]), ms1[m]);
        chk({P_NAME[m], ".fwd_sel2"}, int'(o_s2[m]), ms2[m]);
        chk({P_NAME[m], ".stall_cnt"}, int'(o_cnt[m]), mcnt[m]);
      end
      y1 = -1;
      y2 = -1;
      h  = 1'b0;
      if (!rst && id_valid) begin
        y1 = youngest(m, id_src1);
        if (id_two_src) y2 = youngest(m, id_src2);
        if (P_FWD[m]) h = (y1 == 0 || y2 == 0) && mr[m][0];
        else          h = (y1 >= 0) || (y2 >= 0);
      end
      efl  = branch_taken && !ext_stall;
      eiss = id_valid && !h && !efl && !ext_stall;
      chk({P_NAME[m], ".flush"}, int'(o_fl[m]), int'(efl));
      chk({P_NAME[m], ".freeze"}, int'(o_frz[m]), int'(ext_stall || (h && !efl)));
      chk({P_NAME[m], ".issue"}, int'(o_iss[m]), int'(eiss));
      if (rst) begin
        for (int k = 0; k < 8; k++) begin
          mv[m][k] = 0; md[m][k] = 0; mw[m][k] = 0; mr[m][k] = 0;
        end
        ms1[m] = 0; ms2[m] = 0; mcnt[m] = 0;
      end else if (!ext_stall) begin
        for (int k = P_DEPTH[m] - 1; k >= 1; k--) begin
          mv[m][k] = mv[m][k-1]; md[m][k] = md[m][k-1];
          mw[m][k] = mw[m][k-1]; mr[m][k] = mr[m][k-1];
        end
        mv[m][0] = eiss;
        md[m][0] = eiss ? id_dest : 4'd0;
        mw[m][0] = eiss && id_wb_en;
        mr[m][0] = eiss && id_mem_r_en;
        ms1[m] = (eiss && P_FWD[m] && y1 >= 0) ? y1 + 1 : 0;
        ms2[m] = (eiss && P_FWD[m] && y2 >= 0) ? y2 + 1 : 0;
        if (h && id_valid && !efl && mcnt[m] < P_MAX[m]) mcnt[m]++;
      end
    end
    if (rst) known = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input logic [3:0] s1, input logic [3:0] s2, input bit two,
                        input logic [3:0] d, input bit wb, input bit ld);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dest = d; id_wb_en = wb; id_mem_r_en = ld;
    branch_taken = 1'b0; ext_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    chk("reset.A.stall_cnt", int'(o_cnt[0]), 0);
    chk("reset.C.exe_valid", int'(o_ev[2]), 0);

    // Stall-only: writer of r2, then reader of r2 waits two cycles on B
    set_id(1, 2, 7, 0, 2, 1, 0); cycle();
    set_id(1, 2, 7, 0, 8, 0, 0);
    #1 chk("d37.B.freeze1", int'(o_frz[1]), 1);
    cycle();
    chk("d38.A.fwd_sel1_adj", int'(o_s1[0]), 1);
    #1 chk("d37.B.freeze2", int'(o_frz[1]), 1);
    cycle();
    #1 chk("d37.B.issue", int'(o_iss[1]), 1);
    chk("d37.B.freeze3", int'(o_frz[1]), 0);
    cycle();
    chk("d37.B.fwd_sel1", int'(o_s1[1]), 0);
    chk("d37.B.stall_cnt", int'(o_cnt[1]), 2);

    // Forwarding: ALU result one and two instructions back
    do_reset();
    set_id(1, 10, 10, 0, 5, 1, 0); cycle();
    set_id(1, 5, 10, 0, 9, 0, 0);
    #1 chk("d38.A.nofreeze", int'(o_frz[0]), 0);
    cycle();
    chk("d38.A.sel1_k0", int'(o_s1[0]), 1);
    set_id(1, 10, 10, 0, 5, 1, 0); cycle();
    set_id(1, 10, 10, 0, 6, 1, 0); cycle();
    set_id(1, 5, 10, 0, 9, 0, 0); cycle();
    chk("d38.A.sel1_k1", int'(o_s1[0]), 2);

    // Load-use on src2, then the same with src2 unused
    do_reset();
    set_id(1, 10, 10, 0, 3, 1, 1); cycle();
    set_id(1, 10, 3, 1, 11, 0, 0);
    #1 chk("d39.A.freeze", int'(o_frz[0]), 1);
    cycle();
    #1 chk("d39.A.issue", int'(o_iss[0]), 1);
    cycle();
    chk("d39.A.fwd_sel2", int'(o_s2[0]), 2);
    do_reset();
    set_id(1, 10, 10, 0, 3, 1, 1); cycle();
    set_id(1, 10, 3, 0, 11, 0, 0);
    #1 chk("d39.A.one_src_nofreeze", int'(o_frz[0]), 0);
    cycle();
    chk("d39.A.one_src_sel2", int'(o_s2[0]), 0);

    // Taken branch overrides a load-use stall
    do_reset();
    set_id(1, 10, 10, 0, 3, 1, 1); cycle();
    set_id(1, 3, 10, 0, 11, 0, 0);
    branch_taken = 1'b1;
    #1 chk("d40.A.flush", int'(o_fl[0]), 1);
    chk("d40.A.freeze", int'(o_frz[0]), 0);
    chk("d40.A.issue", int'(o_iss[0]), 0);
    cycle();
    chk("d40.A.exe_bubble", int'(o_ev[0]), 0);
    chk("d40.A.stall_cnt", int'(o_cnt[0]), 0);

    // External stall holds everything, then the pipeline resumes
    do_reset();
    set_id(1, 10, 10, 0, 4, 1, 0); cycle();
    set_id(1, 4, 10, 0, 5, 1, 0); cycle();
    set_id(1, 4, 10, 0, 12, 0, 0);
    ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("d41.A.freeze", int'(o_frz[0]), 1);
      cycle();
      chk("d41.A.sel1_held", int'(o_s1[0]), 1);
      chk("d41.A.exe_held", int'(o_ev[0]), 1);
    end
    ext_stall = 1'b0;
    cycle();
    chk("d41.A.resume_sel1", int'(o_s1[0]), 2);

    // Counter saturation on the 4-bit configuration, then reset mid-stream
    do_reset();
    set_id(1, 1, 1, 0, 1, 1, 0);
    repeat (40) cycle();
    chk("d42.C.saturated", int'(o_cnt[2]), 15);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("d42.C.cnt_reset", int'(o_cnt[2]), 0);
    chk("d42.C.ev_reset", int'(o_ev[2]), 0);
    chk("d42.B.sel1_reset", int'(o_s1[1]), 0);

    // Randomized traffic on a small register range to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(63) == 0);
      id_valid     = ($urandom_range(9) < 8);
      id_src1      = 4'($urandom_range(3));
      id_src2      = 4'($urandom_range(3));
      id_two_src   = $urandom_range(1) == 1;
      id_dest      = 4'($urandom_range(3));
      id_wb_en     = ($urandom_range(3) != 0);
      id_mem_r_en  = ($urandom_range(2) == 0);
      branch_taken = ($urandom_range(9) == 0);
      ext_stall    = ($urandom_range(9) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
